// File: rtl/ex_mem_flags.sv
// EX/MEM pipeline register with the architectural Z/V/N flag registers and the
// branch-condition evaluator, which bypasses same-cycle flag updates.
module ex_mem_flags (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [3:0]  aluop,
  input  logic [15:0] aluout,
  input  logic        err,
  input  logic [3:0]  ex_rd,
  input  logic        ex_wen,
  input  logic        br_eval,
  input  logic [2:0]  ccc,
  output logic        mem_valid,
  output logic [15:0] mem_aluout,
  output logic [3:0]  mem_rd,
  output logic        mem_wen,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n,
  output logic        br_taken
);

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_XOR    = 4'd2,
    OP_RED    = 4'd3,
    OP_SLL    = 4'd4,
    OP_SRA    = 4'd5,
    OP_ROR    = 4'd6,
    OP_PADDSB = 4'd7,
    OP_LLB    = 4'd8,
    OP_LHB    = 4'd9
  } aluop_e;

  typedef enum logic [2:0] {
    CC_NE = 3'b000,
    CC_EQ = 3'b001,
    CC_GT = 3'b010,
    CC_LT = 3'b011,
    CC_GE = 3'b100,
    CC_LE = 3'b101,
    CC_OV = 3'b110,
    CC_UN = 3'b111
  } ccc_e;

  aluop_e      op;
  ccc_e        cc;
  logic        upd;
  logic        set_zvn;
  logic        set_z;
  logic        cond;

  logic        mem_valid_q, mem_valid_d;
  logic [15:0] mem_aluout_q, mem_aluout_d;
  logic [3:0]  mem_rd_q, mem_rd_d;
  logic        mem_wen_q, mem_wen_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_v_q, flag_v_d;
  logic        flag_n_q, flag_n_d;

  assign op  = aluop_e'(aluop);
  assign cc  = ccc_e'(ccc);
  assign upd = ex_valid & ~stall & ~flush;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    set_zvn = 1'b0;
    set_z   = 1'b0;
    case (op)
      OP_ADD, OP_SUB:                 set_zvn = 1'b1;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: set_z   = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    mem_valid_d  = mem_valid_q;
    mem_aluout_d = mem_aluout_q;
    mem_rd_d     = mem_rd_q;
    mem_wen_d    = mem_wen_q;
    if (flush) begin
      // Squash only kills the slot; payload fields keep their old values.
      mem_valid_d = 1'b0;
      mem_wen_d   = 1'b0;
    end else if (!stall) begin
      mem_valid_d  = ex_valid;
      mem_aluout_d = aluout;
      mem_rd_d     = ex_rd;
      mem_wen_d    = ex_valid & ex_wen;
    end
  end

  // Z comes straight from the ALU result; no arithmetic is redone here.
  always_comb begin
    flag_z_d = flag_z_q;
    flag_v_d = flag_v_q;
    flag_n_d = flag_n_q;
    if (upd && (set_zvn || set_z)) flag_z_d = (aluout == 16'h0000);
    if (upd && set_zvn) begin
      flag_v_d = err;
      flag_n_d = aluout[15];
    end
  end

  // The next-state flags equal the registered ones unless upd, so using them
  // directly gives the same-cycle bypass the branch unit needs.
  always_comb begin
    cond = 1'b0;
    case (cc)
      CC_NE: cond = ~flag_z_d;
      CC_EQ: cond = flag_z_d;
      CC_GT: cond = ~flag_z_d & ~flag_n_d;
      CC_LT: cond = flag_n_d;
      CC_GE: cond = flag_z_d | (~flag_z_d & ~flag_n_d);
      CC_LE: cond = flag_n_d | flag_z_d;
      CC_OV: cond = flag_v_d;
      CC_UN: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign br_taken = br_eval & ~flush & cond;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_q  <= 1'b0;
      mem_aluout_q <= 16'h0000;
      mem_rd_q     <= 4'h0;
      mem_wen_q    <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_v_q     <= 1'b0;
      flag_n_q     <= 1'b0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      mem_aluout_q <= mem_aluout_d;
      mem_rd_q     <= mem_rd_d;
      mem_wen_q    <= mem_wen_d;
      flag_z_q     <= flag_z_d;
      flag_v_q     <= flag_v_d;
      flag_n_q     <= flag_n_d;
    end
  end

  assign mem_valid  = mem_valid_q;
  assign mem_aluout = mem_aluout_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wen    = mem_wen_q;
  assign flag_z     = flag_z_q;
  assign flag_v     = flag_v_q;
  assign flag_n     = flag_n_q;

endmodule

// File: tb/tb_ex_mem_flags.sv
// Self-checking bench for ex_mem_flags: a vector table of per-cycle stimulus
// with expected branch decision and expected post-edge register state.
module tb_ex_mem_flags;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid, err, ex_wen, br_eval;
  logic [3:0]  aluop, ex_rd;
  logic [15:0] aluout;
  logic [2:0]  ccc;
  logic        mem_valid, mem_wen, flag_z, flag_v, flag_n, br_taken;
  logic [15:0] mem_aluout;
  logic [3:0]  mem_rd;

  always #5 clk = ~clk;

  ex_mem_flags dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .aluop(aluop), .aluout(aluout), .err(err), .ex_rd(ex_rd), .ex_wen(ex_wen),
    .br_eval(br_eval), .ccc(ccc), .mem_valid(mem_valid), .mem_aluout(mem_aluout),
    .mem_rd(mem_rd), .mem_wen(mem_wen), .flag_z(flag_z), .flag_v(flag_v),
    .flag_n(flag_n), .br_taken(br_taken)
  );

  typedef struct packed {
    logic        rst, stall, flush, ex_valid;
    logic [3:0]  aluop;
    logic [15:0] aluout;
    logic        err;
    logic [3:0]  ex_rd;
    logic        ex_wen, br_eval;
    logic [2:0]  ccc;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] aluout;
    logic [3:0]  rd;
    logic        wen, z, v, n;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    logic  br;
    out_t  exp;
  } vec_t;

  vec_t tbl[$];
  out_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t s);
    rst = s.rst; stall = s.stall; flush = s.flush; ex_valid = s.ex_valid;
    aluop = s.aluop; aluout = s.aluout; err = s.err; ex_rd = s.ex_rd;
    ex_wen = s.ex_wen; br_eval = s.br_eval; ccc = s.ccc;
  endtask

  // Drive one cycle: br_taken is checked before the edge, registers after it.
  task automatic apply(input string name, input in_t s, input logic br, input out_t e);
    out_t exp_o;
    out_t act_o;
    @(negedge clk);
    drive(s);
    sb.push_back(e);
    #1 check({name, " br_taken"}, {31'd0, br_taken}, {31'd0, br});
    @(posedge clk);
    #1;
    act_o = '{mem_valid, mem_aluout, mem_rd, mem_wen, flag_z, flag_v, flag_n};
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp_o = sb.pop_front();
      check({name, " regs"}, {7'd0, act_o}, {7'd0, exp_o});
    end
  endtask

  task automatic add(input string name, input in_t s, input logic br, input out_t e);
    vec_t v;
    v.name = name; v.in = s; v.br = br; v.exp = e;
    tbl.push_back(v);
  endtask

  out_t cur;

  initial begin
    drive(in_t'(0));
    //      name            rst   stall flush exv   op    aluout    err   rd    wen   bre   ccc              br      valid aluout    rd    wen   z     v     n
    add("reset",      in_t'{1'b1,1'b0,1'b0,1'b0,4'h0,16'h0000,1'b0,4'h0,1'b0,1'b0,3'd0}, 1'b0, out_t'{1'b0,16'h0000,4'h0,1'b0,1'b0,1'b0,1'b0});
    add("add",        in_t'{1'b0,1'b0,1'b0,1'b1,4'h0,16'h1d52,1'b1,4'h3,1'b1,1'b0,3'd0}, 1'b0, out_t'{1'b1,16'h1d52,4'h3,1'b1,1'b0,1'b1,1'b0});
    add("sub_ov",     in_t'{1'b0,1'b0,1'b0,1'b1,4'h1,16'h0000,1'b0,4'h4,1'b1,1'b1,3'd6}, 1'b0, out_t'{1'b1,16'h0000,4'h4,1'b1,1'b1,1'b0,1'b0});
    add("xor_lt",     in_t'{1'b0,1'b0,1'b0,1'b1,4'h2,16'he128,1'b1,4'h5,1'b0,1'b1,3'd3}, 1'b0, out_t'{1'b1,16'he128,4'h5,1'b0,1'b0,1'b0,1'b0});
    add("bypass_eq",  in_t'{1'b0,1'b0,1'b0,1'b1,4'h0,16'h0000,1'b0,4'h6,1'b1,1'b1,3'd1}, 1'b1, out_t'{1'b1,16'h0000,4'h6,1'b1,1'b1,1'b0,1'b0});
    add("add_le",     in_t'{1'b0,1'b0,1'b0,1'b1,4'h0,16'h8000,1'b1,4'h7,1'b1,1'b1,3'd5}, 1'b1, out_t'{1'b1,16'h8000,4'h7,1'b1,1'b0,1'b1,1'b1});
    add("sub_gt",     in_t'{1'b0,1'b0,1'b0,1'b1,4'h1,16'h0001,1'b0,4'h1,1'b1,1'b1,3'd2}, 1'b1, out_t'{1'b1,16'h0001,4'h1,1'b1,1'b0,1'b0,1'b0});
    for (int i = 0; i < 3; i++)
      add("stall",    in_t'{1'b0,1'b1,1'b0,1'b1,4'h0,16'h8000,1'b0,4'h2,1'b1,1'b1,3'd3}, 1'b0, out_t'{1'b1,16'h0001,4'h1,1'b1,1'b0,1'b0,1'b0});
    add("release_ge", in_t'{1'b0,1'b0,1'b0,1'b1,4'h0,16'h8000,1'b0,4'h2,1'b1,1'b1,3'd4}, 1'b0, out_t'{1'b1,16'h8000,4'h2,1'b1,1'b0,1'b0,1'b1});
    add("flush_stall",in_t'{1'b0,1'b1,1'b1,1'b1,4'h8,16'h1188,1'b0,4'h9,1'b1,1'b1,3'd7}, 1'b0, out_t'{1'b0,16'h8000,4'h2,1'b0,1'b0,1'b0,1'b1});
    add("flush_add",  in_t'{1'b0,1'b0,1'b1,1'b1,4'h0,16'h0000,1'b1,4'h8,1'b1,1'b0,3'd0}, 1'b0, out_t'{1'b0,16'h8000,4'h2,1'b0,1'b0,1'b0,1'b1});
    add("bubble",     in_t'{1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,1'b1,4'ha,1'b1,1'b1,3'd1}, 1'b0, out_t'{1'b0,16'h0000,4'ha,1'b0,1'b0,1'b0,1'b1});
    add("red_ne",     in_t'{1'b0,1'b0,1'b0,1'b1,4'h3,16'h0000,1'b1,4'hb,1'b1,1'b1,3'd0}, 1'b1, out_t'{1'b1,16'h0000,4'hb,1'b1,1'b0,1'b0,1'b1});
    add("reserved",   in_t'{1'b0,1'b0,1'b0,1'b1,4'hf,16'h0000,1'b1,4'hc,1'b1,1'b0,3'd0}, 1'b0, out_t'{1'b1,16'h0000,4'hc,1'b1,1'b0,1'b0,1'b1});
    add("ror_eq",     in_t'{1'b0,1'b0,1'b0,1'b1,4'h6,16'h0000,1'b1,4'hd,1'b0,1'b1,3'd1}, 1'b1, out_t'{1'b1,16'h0000,4'hd,1'b0,1'b1,1'b0,1'b1});
    add("sra_z",      in_t'{1'b0,1'b0,1'b0,1'b1,4'h5,16'h0000,1'b1,4'he,1'b1,1'b1,3'd0}, 1'b0, out_t'{1'b1,16'h0000,4'he,1'b1,1'b1,1'b0,1'b1});
    add("rst_stall",  in_t'{1'b1,1'b1,1'b0,1'b1,4'h0,16'hffff,1'b1,4'hf,1'b1,1'b1,3'd0}, 1'b0, out_t'{1'b0,16'h0000,4'h0,1'b0,1'b0,1'b0,1'b0});
    add("post_rst_ne",in_t'{1'b0,1'b0,1'b0,1'b0,4'h0,16'h0000,1'b0,4'h0,1'b0,1'b1,3'd0}, 1'b1, out_t'{1'b0,16'h0000,4'h0,1'b0,1'b0,1'b0,1'b0});
    add("rst_bypass", in_t'{1'b1,1'b0,1'b0,1'b1,4'h0,16'h0000,1'b0,4'h0,1'b1,1'b1,3'd1}, 1'b1, out_t'{1'b0,16'h0000,4'h0,1'b0,1'b0,1'b0,1'b0});
    add("lhb",        in_t'{1'b0,1'b0,1'b0,1'b1,4'h9,16'h0000,1'b1,4'h1,1'b1,1'b1,3'd1}, 1'b0, out_t'{1'b1,16'h0000,4'h1,1'b1,1'b0,1'b0,1'b0});

    foreach (tbl[i]) apply(tbl[i].name, tbl[i].in, tbl[i].br, tbl[i].exp);

    // Long stall with changing EX data must leave everything untouched.
    cur = out_t'{1'b1,16'h0000,4'h1,1'b1,1'b0,1'b0,1'b0};
    for (int i = 0; i < 4; i++)
      apply("stall_hold", in_t'{1'b0,1'b1,1'b0,1'b1,4'h0,16'($urandom_range(1,16'hffff)),1'b1,4'h5,1'b1,1'b0,3'd0}, 1'b0, cur);
    apply("release_ov", in_t'{1'b0,1'b0,1'b0,1'b1,4'h0,16'h0000,1'b1,4'h5,1'b1,1'b1,3'd6}, 1'b1, out_t'{1'b1,16'h0000,4'h5,1'b1,1'b1,1'b1,1'b0});
    apply("flush_unc",  in_t'{1'b0,1'b0,1'b1,1'b1,4'h0,16'h4321,1'b0,4'h7,1'b1,1'b1,3'd7}, 1'b0, out_t'{1'b0,16'h0000,4'h5,1'b0,1'b1,1'b1,1'b0});
    apply("unc_bubble", in_t'{1'b0,1'b0,1'b0,1'b0,4'h0,16'h1234,1'b0,4'h6,1'b1,1'b1,3'd7}, 1'b1, out_t'{1'b0,16'h1234,4'h6,1'b0,1'b1,1'b1,1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_flags.md
EX_MEM_FLAGS -- requirements
Module: ex_mem_flags

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock, and rst is a synchronous, active-high reset sampled on the rising edge of clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 stall  input  1  hold all registered state this cycle.
REQ-005 flush  input  1  squash the instruction currently in EX.
REQ-006 ex_valid  input  1  EX stage holds a real instruction.
REQ-007 aluop  input  4  opcode driven to the ALU: 0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB, 8 LLB, 9 LHB; A-F reserved.
REQ-008 aluout  input  16  ALU result.
REQ-009 err  input  1  ALU signed-overflow indication.
REQ-010 ex_rd  input  4  destination register of the EX instruction.
REQ-011 ex_wen  input  1  EX instruction writes ex_rd.
REQ-012 br_eval  input  1  a branch in EX requests condition evaluation.
REQ-013 ccc  input  3  branch condition code.
REQ-014 mem_valid  output  1  MEM-stage instruction valid.
REQ-015 mem_aluout  output  16  registered ALU result.
REQ-016 mem_rd  output  4  registered destination register.
REQ-017 mem_wen  output  1  registered write enable, already qualified by mem_valid.
REQ-018 flag_z, flag_v, flag_n  output  1 each  architectural Z, V and N flags.
REQ-019 br_taken  output  1  combinational branch decision.

Function
REQ-020 Update qualifier: upd = ex_valid & ~stall & ~flush.
REQ-021 The pipeline register SHALL load on every rising edge of clk when neither stall nor flush is asserted, using these values:
- mem_valid <= ex_valid
- mem_aluout <= aluout
- mem_rd <= ex_rd
- mem_wen <= ex_valid & ex_wen
REQ-022 Latency SHALL be exactly one cycle from EX inputs to mem_* outputs.
REQ-023 While stall=1 and flush=0, all pipeline registers and flags SHALL hold their values.
REQ-024 When flush=1, regardless of stall:
- mem_valid <= 0 and mem_wen <= 0
- mem_aluout and mem_rd hold their values
- flags are not updated
REQ-025 When upd=1 and aluop is ADD or SUB, the flags SHALL update as follows:
- Z <= (aluout == 16'h0000)
- V <= err
- N <= aluout[15]
REQ-026 When upd=1 and aluop is XOR, SLL, SRA or ROR, only Z SHALL update; V and N hold.
REQ-027 When aluop is RED, PADDSB, LLB, LHB or a reserved code, no flag SHALL change.
REQ-028 The Z flag SHALL be computed from the 16-bit aluout as delivered by the ALU, which is already saturated or wrapped; the block SHALL NOT recompute any arithmetic.
REQ-029 Effective flags (fz, fv, fn) SHALL be the values the flag registers would take at the next edge when upd=1, and the registered values otherwise. This bypass lets a branch evaluated in the same cycle as a flag-setting instruction see the new flags.
REQ-030 br_taken = br_eval & ~flush & cond, where cond is selected by ccc:
- 000 NE: ~fz
- 001 EQ: fz
- 010 GT: ~fz & ~fn
- 011 LT: fn
- 100 GE: fz | (~fz & ~fn)
- 101 LE: fn | fz
- 110 OV: fv
- 111 unconditional: 1
REQ-031 br_taken SHALL be 0 whenever br_eval=0, and it is not masked by stall.
REQ-032 An invalid EX slot (ex_valid=0) SHALL propagate as a bubble and SHALL NOT modify any flag.

Reset
REQ-033 When rst=1 at a rising edge of clk, the block SHALL reset: mem_valid, mem_wen, mem_aluout, mem_rd, flag_z, flag_v and flag_n all go to 0.
REQ-034 Reset SHALL take priority over stall and flush.
REQ-035 During reset, br_taken SHALL follow REQ-030 using the zeroed registered flags, with no bypass unless upd=1.
REQ-036 Assertion of rst mid-stall SHALL discard the held instruction.

Verification
REQ-037 The bench SHALL cover the following scenarios:
- ADD: aluout=1d52, err=1, ex_valid=1, ex_wen=1, ex_rd=3 -> next cycle mem_aluout=1d52, mem_rd=3, mem_wen=1, Z=0, V=1, N=0.
- SUB then XOR: SUB with aluout=0000, err=0 -> Z=1, V=0, N=0; then XOR with aluout=e128 -> Z=0 while V and N hold 0.
- Same-cycle bypass: Z=0 registered; ADD with aluout=0000, br_eval=1, ccc=001 in the same cycle -> br_taken=1 that cycle; Z=1 the next cycle.
- Stall: stall=1 for 3 cycles while an ADD with aluout=8000 is presented -> mem_* outputs and flags are unchanged for all 3 cycles; on release -> N=1.
- Flush with stall: flush=1 and stall=1 with LLB aluout=1188 -> next cycle mem_valid=0 and mem_wen=0; flags unchanged; br_taken=0.
- Reset: rst=1 for 1 cycle after nonzero state -> every output register is 0; with br_eval=1 and ccc=000 -> br_taken=1.
